// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_pkg
//  Brief    : Shared widths, buffer entry type and one-hot decode helper for
//             the buffered 1-to-8 demultiplexer.
//  Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

   localparam int DATA_W  = 32;
   localparam int DEST_W  = 3;
   localparam int NUM_OUT = 8;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [DEST_W-1:0] dest;
   } entry_t;

   function automatic logic [NUM_OUT-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
      logic [NUM_OUT-1:0] v;
      v       = '0;
      v[dest] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/demux_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : demux_skid_buffer
//  Brief    : Two-entry FIFO of demux entries with registered not_full flag.
//  Revision : 1.0  initial release
// ============================================================================
module demux_skid_buffer
   import demux_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_push,
   input  entry_t i_push_entry,
   input  logic   i_pop,
   output logic   o_not_full,
   output logic   o_head_valid,
   output entry_t o_head
);

   localparam logic [1:0] c_cnt_empty = 2'd0;
   localparam logic [1:0] c_cnt_one   = 2'd1;
   localparam logic [1:0] c_cnt_full  = 2'd2;

   logic [1:0] r_count;
   logic [1:0] w_count_next;
   logic       r_not_full;
   entry_t     r_head;
   entry_t     r_tail;
   logic       w_push;
   logic       w_pop;

   assign w_push = i_push & r_not_full;
   assign w_pop  = i_pop & (r_count != c_cnt_empty);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + c_cnt_one;
         2'b01:   w_count_next = r_count - c_cnt_one;
         default: w_count_next = r_count;
      endcase
   end

   // Head register keeps its last value when the buffer drains so the data
   // outputs do not glitch while valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= c_cnt_empty;
         r_not_full <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         r_count    <= w_count_next;
         r_not_full <= (w_count_next != c_cnt_full);
         if (w_pop) begin
            if (r_count == c_cnt_full) begin
               r_head <= r_tail;
            end else if (w_push) begin
               r_head <= i_push_entry;
            end
         end else if (w_push) begin
            if (r_count == c_cnt_empty) begin
               r_head <= i_push_entry;
            end else begin
               r_tail <= i_push_entry;
            end
         end
      end
   end

   assign o_not_full   = r_not_full;
   assign o_head_valid = (r_count != c_cnt_empty);
   assign o_head       = r_head;

endmodule
`default_nettype wire

// File: rtl/demux_1to8_32b_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1to8_32b_buffered
//  Brief    : Registered 1-to-8 demultiplexer with valid/ready flow control
//             and a 2-entry skid buffer (strict FIFO, head-of-line blocking).
//  Revision : 1.0  initial release
// ============================================================================
module demux_1to8_32b_buffered
   import demux_pkg::*;
#(
   parameter int size  = 32,
   parameter int DEPTH = 2
)
(
   input  logic            CGRA_Clock,
   input  logic            CGRA_Reset,
   input  logic [size-1:0] in,
   input  logic [2:0]      select,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [size-1:0] out0,
   output logic [size-1:0] out1,
   output logic [size-1:0] out2,
   output logic [size-1:0] out3,
   output logic [size-1:0] out4,
   output logic [size-1:0] out5,
   output logic [size-1:0] out6,
   output logic [size-1:0] out7,
   output logic [7:0]      out_valid,
   input  logic [7:0]      out_ready
);

   generate
      if (DEPTH != 2) begin : g_bad_depth
         $error("demux_1to8_32b_buffered: DEPTH must be 2");
      end
      if (size != DATA_W) begin : g_bad_size
         $error("demux_1to8_32b_buffered: size must match demux_pkg::DATA_W");
      end
   endgenerate

   entry_t w_push_entry;
   entry_t w_head;
   logic   w_head_valid;
   logic   w_not_full;
   logic   w_pop;

   assign w_push_entry.data = in;
   assign w_push_entry.dest = select;

   // Only the ready bit of the head's destination can retire it.
   assign w_pop = w_head_valid & out_ready[w_head.dest];

   demux_skid_buffer u_buf (
      .clk          (CGRA_Clock),
      .rst_n        (CGRA_Reset),
      .i_push       (in_valid),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_not_full   (w_not_full),
      .o_head_valid (w_head_valid),
      .o_head       (w_head)
   );

   assign in_ready  = w_not_full;
   assign out_valid = w_head_valid ? dest_onehot(w_head.dest) : '0;

   assign out0 = w_head.data;
   assign out1 = w_head.data;
   assign out2 = w_head.data;
   assign out3 = w_head.data;
   assign out4 = w_head.data;
   assign out5 = w_head.data;
   assign out6 = w_head.data;
   assign out7 = w_head.data;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to8_32b_buffered.sv
`default_nettype none
// Directed and randomised checks of the buffered 1-to-8 demultiplexer.
module tb_demux_1to8_32b_buffered;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] din = '0;
   logic [2:0]  sel = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready = '0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   demux_1to8_32b_buffered #(.size(32), .DEPTH(2)) dut (
      .CGRA_Clock (clk),
      .CGRA_Reset (rst_n),
      .in         (din),
      .select     (sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0       (o0),
      .out1       (o1),
      .out2       (o2),
      .out3       (o3),
      .out4       (o4),
      .out5       (o5),
      .out6       (o6),
      .out7       (o7),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   function automatic logic [31:0] get_out(input logic [2:0] k);
      case (k)
         3'd0:    return o0;
         3'd1:    return o1;
         3'd2:    return o2;
         3'd3:    return o3;
         3'd4:    return o4;
         3'd5:    return o5;
         3'd6:    return o6;
         default: return o7;
      endcase
   endfunction

   // Apply inputs, let one rising edge pass, then settle before sampling.
   task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d,
                        input logic [7:0] r);
      in_valid  = v;
      sel       = s;
      din       = d;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (in_ready !== 1'b0)     begin failures++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
      checks++; if (out_valid !== 8'h00)   begin failures++; $display("FAIL reset_out_valid got %h expected 00", out_valid); end
      checks++; if (o0 !== 32'h0)          begin failures++; $display("FAIL reset_out0 got %h expected 00000000", o0); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 8'hFF);
      checks++; if (in_ready !== 1'b1)     begin failures++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
      checks++; if (out_valid !== 8'h00)   begin failures++; $display("FAIL release_out_valid got %h expected 00", out_valid); end
   endtask

   task automatic test_streaming();
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = 32'h11111111 * (i + 1);
         drive(1'b1, 3'(i), d, 8'hFF);
         checks++; if (out_valid !== (8'h01 << i)) begin failures++; $display("FAIL stream_valid[%0d] got %h expected %h", i, out_valid, 8'h01 << i); end
         checks++; if (get_out(3'(i)) !== d)      begin failures++; $display("FAIL stream_data[%0d] got %h expected %h", i, get_out(3'(i)), d); end
         checks++; if (in_ready !== 1'b1)         begin failures++; $display("FAIL stream_in_ready[%0d] got %b expected 1", i, in_ready); end
      end
      drive(1'b0, 3'd0, 32'h0, 8'hFF);
      checks++; if (out_valid !== 8'h00) begin failures++; $display("FAIL stream_drain got %h expected 00", out_valid); end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 3'd3, 32'hA5A5A5A5, 8'h00);
      checks++; if (out_valid !== 8'h08)      begin failures++; $display("FAIL bp_first_valid got %h expected 08", out_valid); end
      checks++; if (o3 !== 32'hA5A5A5A5)      begin failures++; $display("FAIL bp_first_data got %h expected a5a5a5a5", o3); end
      checks++; if (in_ready !== 1'b1)        begin failures++; $display("FAIL bp_first_ready got %b expected 1", in_ready); end
      drive(1'b1, 3'd6, 32'h5A5A5A5A, 8'h00);
      checks++; if (out_valid !== 8'h08)      begin failures++; $display("FAIL bp_full_valid got %h expected 08", out_valid); end
      checks++; if (in_ready !== 1'b0)        begin failures++; $display("FAIL bp_full_ready got %b expected 0", in_ready); end
      // Offered while full: must not be taken.
      drive(1'b1, 3'd1, 32'h12345678, 8'h00);
      checks++; if (out_valid !== 8'h08)      begin failures++; $display("FAIL bp_hold_valid got %h expected 08", out_valid); end
      checks++; if (o3 !== 32'hA5A5A5A5)      begin failures++; $display("FAIL bp_hold_data got %h expected a5a5a5a5", o3); end
      checks++; if (in_ready !== 1'b0)        begin failures++; $display("FAIL bp_hold_ready got %b expected 0", in_ready); end
      drive(1'b0, 3'd0, 32'h0, 8'h08);
      checks++; if (out_valid !== 8'h40)      begin failures++; $display("FAIL bp_pop_valid got %h expected 40", out_valid); end
      checks++; if (o6 !== 32'h5A5A5A5A)      begin failures++; $display("FAIL bp_pop_data got %h expected 5a5a5a5a", o6); end
      checks++; if (in_ready !== 1'b1)        begin failures++; $display("FAIL bp_pop_ready got %b expected 1", in_ready); end
      drive(1'b0, 3'd0, 32'h0, 8'hFF);
      checks++; if (out_valid !== 8'h00)      begin failures++; $display("FAIL bp_empty_valid got %h expected 00", out_valid); end
      checks++; if (o6 !== 32'h5A5A5A5A)      begin failures++; $display("FAIL bp_empty_hold got %h expected 5a5a5a5a", o6); end
   endtask

   task automatic test_wrong_ready();
      drive(1'b1, 3'd5, 32'h0BADCAFE, 8'hDF);
      checks++; if (out_valid !== 8'h20) begin failures++; $display("FAIL wr_push_valid got %h expected 20", out_valid); end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 3'd0, 32'h0, 8'hDF);
         checks++; if (out_valid !== 8'h20)   begin failures++; $display("FAIL wr_valid[%0d] got %h expected 20", i, out_valid); end
         checks++; if (o5 !== 32'h0BADCAFE)   begin failures++; $display("FAIL wr_data[%0d] got %h expected 0badcafe", i, o5); end
      end
      drive(1'b0, 3'd0, 32'h0, 8'hFF);
      checks++; if (out_valid !== 8'h00) begin failures++; $display("FAIL wr_release got %h expected 00", out_valid); end
   endtask

   task automatic test_push_pop();
      drive(1'b1, 3'd2, 32'hDEADBEEF, 8'h00);
      checks++; if (out_valid !== 8'h04)     begin failures++; $display("FAIL pp_first_valid got %h expected 04", out_valid); end
      checks++; if (o2 !== 32'hDEADBEEF)     begin failures++; $display("FAIL pp_first_data got %h expected deadbeef", o2); end
      drive(1'b1, 3'd2, 32'hCAFEF00D, 8'h04);
      checks++; if (out_valid !== 8'h04)     begin failures++; $display("FAIL pp_swap_valid got %h expected 04", out_valid); end
      checks++; if (o2 !== 32'hCAFEF00D)     begin failures++; $display("FAIL pp_swap_data got %h expected cafef00d", o2); end
      checks++; if (in_ready !== 1'b1)       begin failures++; $display("FAIL pp_swap_ready got %b expected 1", in_ready); end
      drive(1'b0, 3'd0, 32'h0, 8'hFF);
      checks++; if (out_valid !== 8'h00)     begin failures++; $display("FAIL pp_drain got %h expected 00", out_valid); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 3'd1, 32'h01010101, 8'h00);
      drive(1'b1, 3'd4, 32'h04040404, 8'h00);
      checks++; if (out_valid !== 8'h02)   begin failures++; $display("FAIL rm_loaded_valid got %h expected 02", out_valid); end
      checks++; if (in_ready !== 1'b0)     begin failures++; $display("FAIL rm_loaded_ready got %b expected 0", in_ready); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 8'h00)   begin failures++; $display("FAIL rm_async_valid got %h expected 00", out_valid); end
      checks++; if (o1 !== 32'h0)          begin failures++; $display("FAIL rm_async_data got %h expected 00000000", o1); end
      checks++; if (in_ready !== 1'b0)     begin failures++; $display("FAIL rm_async_ready got %b expected 0", in_ready); end
      in_valid  = 1'b1;
      out_ready = 8'hFF;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 8'h00)   begin failures++; $display("FAIL rm_held_valid got %h expected 00", out_valid); end
      rst_n = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 8'hFF);
      checks++; if (in_ready !== 1'b1)     begin failures++; $display("FAIL rm_release_ready got %b expected 1", in_ready); end
      checks++; if (out_valid !== 8'h00)   begin failures++; $display("FAIL rm_release_valid got %h expected 00", out_valid); end
      drive(1'b0, 3'd0, 32'h0, 8'hFF);
      checks++; if (out_valid !== 8'h00)   begin failures++; $display("FAIL rm_no_stale got %h expected 00", out_valid); end
   endtask

   task automatic test_random();
      logic [34:0] q[$];
      logic [34:0] head;
      logic        v;
      logic [2:0]  s;
      logic [31:0] d;
      logic [7:0]  r;
      logic        push;
      logic        pop;
      logic [7:0]  exp_valid;
      logic        exp_ready;
      for (int i = 0; i < 10000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         s = 3'($urandom_range(0, 7));
         d = $urandom;
         r = 8'($urandom_range(0, 255));
         push = v && (q.size() != 2);
         pop  = 1'b0;
         if (q.size() != 0) begin
            head = q[0];
            pop  = r[head[2:0]];
         end
         drive(v, s, d, r);
         if (pop)  void'(q.pop_front());
         if (push) q.push_back({d, s});
         exp_valid = 8'h00;
         if (q.size() != 0) begin
            head      = q[0];
            exp_valid = 8'h01 << head[2:0];
         end
         exp_ready = (q.size() != 2);
         checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc %0d got %h expected %h", i, out_valid, exp_valid); end
         checks++; if (in_ready !== exp_ready)  begin failures++; $display("FAIL rnd_ready cyc %0d got %b expected %b", i, in_ready, exp_ready); end
         if (q.size() != 0) begin
            checks++;
            if (get_out(head[2:0]) !== head[34:3]) begin
               failures++;
               $display("FAIL rnd_data cyc %0d got %h expected %h", i, get_out(head[2:0]), head[34:3]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_wrong_ready();
      test_push_pop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
